ex_muldiv_unit: RTL

- Multi-cycle RV32M multiply/divide sequencer beside the EX-stage ALU.
- Accepts one M-type op from the ID/EX boundary and runs an iterative shift-add multiply or a restoring divide.
- Holds the upstream pipeline with stall_o until the result is ready.
- Presents the result with its destination register for the EX/MEM register to capture on the done cycle.

---
 rtl/ex_muldiv_pkg.sv | 23 ++
 rtl/ex_muldiv_unit_core.sv | 45 ++++
 rtl/ex_muldiv_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared types and constants for the EX-stage RV32M multiply/divide sequencer.
// Holds the FSM state encoding, the funct3 opcodes and the default datapath width.
package ex_muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/ex_muldiv_unit_core.sv
// Iterative unsigned datapath: one shift-add multiply step or one restoring
// divide step per enable, sharing a single 2*XLEN accumulator.
module muldiv_core #(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              en_i,
  input  logic              div_mode_i,
  input  logic [XLEN-1:0]   op_a_i,
  input  logic [XLEN-1:0]   op_b_i,
  output logic [2*XLEN-1:0] acc_nxt_o
);

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic [XLEN:0]     sum;
  logic [XLEN+1:0]   diff;

  // Multiply: acc = {product_hi, multiplier}. Divide: acc = {remainder, quotient}.
  always_comb begin
    sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, {XLEN{acc_q[0]}} & opnd_q};
    diff = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, opnd_q};
    if (div_mode_i) begin
      acc_nxt_o = diff[XLEN+1] ? {acc_q[2*XLEN-2:0], 1'b0}
                               : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_nxt_o = {sum, acc_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else if (load_i) begin
      acc_q  <= {{XLEN{1'b0}}, op_a_i};
      opnd_q <= op_b_i;
    end else if (en_i) begin
      acc_q  <= acc_nxt_o;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide sequencer: FSM, iteration counter, sign handling,
// divide special cases and the result/rd output registers.
//   state | meaning
//   IDLE  | waiting for start_i; latches op, handles divide special cases
//   MUL   | XLEN shift-add steps
//   DIV   | XLEN restoring-divide steps
//   DONE  | result_o/rd_o valid, done_o high for this one cycle
module ex_muldiv_unit
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        f3_q;
  logic              neg_q;
  logic [4:0]        rd_lat_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   result_q;
  logic              done_q;

  logic              op1_sgn, op2_sgn, op1_neg, op2_neg, res_neg;
  logic [XLEN-1:0]   op1_mag, op2_mag;
  logic              is_div, div_zero, div_ovf, special, core_load;
  logic [XLEN-1:0]   special_res;
  logic [2*XLEN-1:0] acc_nxt, prod_fix;
  logic [XLEN-1:0]   mul_res, div_raw, div_res;

  always_comb begin
    op1_sgn = 1'b0;
    op2_sgn = 1'b0;
    case (funct3_i)
      F3_MULH:         begin op1_sgn = 1'b1; op2_sgn = 1'b1; end
      F3_MULHSU:       op1_sgn = 1'b1;
      F3_DIV, F3_REM:  begin op1_sgn = 1'b1; op2_sgn = 1'b1; end
      default:         ;
    endcase
    op1_neg = op1_sgn & op1_i[XLEN-1];
    op2_neg = op2_sgn & op2_i[XLEN-1];
    op1_mag = op1_neg ? -op1_i : op1_i;
    op2_mag = op2_neg ? -op2_i : op2_i;
    is_div  = funct3_i[2];
    // Remainder follows the dividend's sign; everything else uses the XOR.
    res_neg = (is_div && funct3_i[1]) ? op1_neg : (op1_neg ^ op2_neg);
    div_zero = (op2_i == '0);
    div_ovf  = !funct3_i[0] && (op1_i == MIN_NEG) && (op2_i == '1);
    special  = is_div && (div_zero || div_ovf);
    if (div_zero) special_res = funct3_i[1] ? op1_i : '1;
    else          special_res = funct3_i[1] ? '0 : MIN_NEG;
  end

  assign core_load = (state_q == IDLE) && start_i && !special;

  muldiv_core #(.XLEN(XLEN)) u_core (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (core_load),
    .en_i       ((state_q == MUL) || (state_q == DIV)),
    .div_mode_i (state_q == DIV),
    .op_a_i     (is_div ? op1_mag : op2_mag),
    .op_b_i     (is_div ? op2_mag : op1_mag),
    .acc_nxt_o  (acc_nxt)
  );

  // Sign fix-up uses the final step's value so the result lands on DONE entry.
  always_comb begin
    prod_fix = neg_q ? -acc_nxt : acc_nxt;
    mul_res  = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    div_raw  = f3_q[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
    div_res  = neg_q ? -div_raw : div_raw;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      rd_lat_q <= '0;
      rd_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            f3_q     <= funct3_i;
            rd_lat_q <= rd_i;
            neg_q    <= res_neg;
            cnt_q    <= '0;
            if (special) begin
              result_q <= special_res;
              rd_q     <= rd_i;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              state_q  <= is_div ? DIV : MUL;
            end
          end
        end
        MUL, DIV: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            result_q <= (state_q == MUL) ? mul_res : div_res;
            rd_q     <= rd_lat_q;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_o  = ((state_q == IDLE) && start_i) || (state_q == MUL) || (state_q == DIV);
  assign done_o   = done_q;
  assign result_o = result_q;
  assign rd_o     = rd_q;

endmodule
